// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM state encodings and ALU control codes.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type functs (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype;

  typedef logic [1:0] aluop_t;

  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to the
// 3-bit ALU function code.
module aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch math; funct decode for R-type
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath through
// fetch/decode/execute/memory/writeback, stalling on mem_ready in the
// memory-access states.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  statetype r_state;
  statetype w_cur;
  statetype w_next;
  aluop_t   w_aluop;
  logic     w_pcwrite;
  logic     w_branch;
  logic     w_irwrite;
  logic     w_memwrite;
  logic     w_regwrite;

  // State register; reset returns to FETCH, aborting any instruction in flight
  always_ff @(posedge clk) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // While reset is low, decode as FETCH so every output shows its reset value
  // from the first cycle, even before the register has been cleared.
  always_comb begin
    w_cur = reset ? r_state : FETCH;
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next     = FETCH;
    w_aluop    = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;
    case (w_cur)
      FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default: begin
            w_next     = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord   = 1'b1;
        w_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
      end
      JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // Write enables are forced off while reset is low
  assign irwrite   = w_irwrite  & reset;
  assign memwrite  = w_memwrite & reset;
  assign regwrite  = w_regwrite & reset;
  assign pcen      = (w_pcwrite | (w_branch & zero)) & reset;
  assign state_dbg = w_cur;

  aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regdst, memtoreg, regwrite;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may be changed afterwards
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Settle combinational outputs after an input change
  task automatic settle();
    #1;
  endtask

  // R-type funct table
  logic [5:0] rt_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  int         rt_alu   [6] = '{2, 6, 0, 1, 7, 2};

  int regw_cnt;
  int memw_cnt;

  initial begin
    reset = 1'b0; mem_ready = 1'b1; op = '0; funct = '0; zero = 1'b0;

    // Reset held for 3 edges with mem_ready=1
    repeat (3) tick();
    check("rst_state", state_dbg, 0);
    check("rst_irwrite", irwrite, 0);
    check("rst_pcen", pcen, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_memwrite", memwrite, 0);
    check("rst_alusrcb", alusrcb, 1);
    check("rst_alucontrol", alucontrol, 2);
    check("rst_iord", iord, 0);

    // Release: FETCH with mem_ready=1
    reset = 1'b1; op = 6'b100011;
    settle();
    check("rel_irwrite", irwrite, 1);
    check("rel_pcen", pcen, 1);

    // lw: 0,1,2,3,4 then back to 0
    regw_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lw_state%0d", i), state_dbg, i);
      if (regwrite) begin
        regw_cnt++;
        check("lw_memtoreg", memtoreg, 1);
        check("lw_regdst", regdst, 0);
      end
      if (i == 2) check("lw_alusrcb", alusrcb, 2);
      if (i == 3) check("lw_iord", iord, 1);
      tick();
    end
    check("lw_regw_cnt", regw_cnt, 1);
    check("lw_back_fetch", state_dbg, 0);

    // sw with two wait cycles in MEMWR
    op = 6'b101011;
    tick(); tick(); tick();
    check("sw_state", state_dbg, 5);
    regw_cnt = 0; memw_cnt = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      settle();
      if (memwrite && iord) memw_cnt++;
      if (regwrite) regw_cnt++;
      tick();
      if (i < 2) check($sformatf("sw_hold%0d", i), state_dbg, 5);
    end
    check("sw_memw_cycles", memw_cnt, 3);
    check("sw_regw", regw_cnt, 0);
    check("sw_back_fetch", state_dbg, 0);

    // R-type across funct values
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = rt_funct[k];
      tick(); tick();
      check($sformatf("rt%0d_state", k), state_dbg, 6);
      check($sformatf("rt%0d_alu", k), alucontrol, rt_alu[k]);
      check($sformatf("rt%0d_srca", k), alusrca, 1);
      check($sformatf("rt%0d_srcb", k), alusrcb, 0);
      tick();
      check($sformatf("rt%0d_regwrite", k), regwrite, 1);
      check($sformatf("rt%0d_regdst", k), regdst, 1);
      tick();
      check($sformatf("rt%0d_fetch", k), state_dbg, 0);
    end

    // beq taken then not taken
    op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      tick();
      check("dec_alusrcb", alusrcb, 3);
      check("dec_alu", alucontrol, 2);
      tick();
      check($sformatf("beq%0d_state", k), state_dbg, 8);
      check($sformatf("beq%0d_pcen", k), pcen, (k == 0) ? 1 : 0);
      check($sformatf("beq%0d_pcsrc", k), pcsrc, 1);
      check($sformatf("beq%0d_alu", k), alucontrol, 6);
      tick();
      check($sformatf("beq%0d_fetch", k), state_dbg, 0);
    end
    zero = 1'b0;

    // j
    op = 6'b000010;
    tick(); tick();
    check("j_state", state_dbg, 11);
    check("j_pcen", pcen, 1);
    check("j_pcsrc", pcsrc, 2);
    tick();
    check("j_fetch", state_dbg, 0);

    // addi
    op = 6'b001000;
    tick(); tick();
    check("addi_state", state_dbg, 9);
    check("addi_srcb", alusrcb, 2);
    tick();
    check("addi_regwrite", regwrite, 1);
    check("addi_regdst", regdst, 0);
    tick();
    check("addi_fetch", state_dbg, 0);

    // Illegal opcode
    op = 6'b111111;
    settle();
    check("ill_fetch_pulse", illegal_op, 0);
    tick();
    check("ill_dec", state_dbg, 1);
    check("ill_pulse", illegal_op, 1);
    tick();
    check("ill_fetch", state_dbg, 0);
    check("ill_pulse_end", illegal_op, 0);

    // FETCH stall
    mem_ready = 1'b0;
    settle();
    check("stall_irwrite", irwrite, 0);
    check("stall_pcen", pcen, 0);
    tick();
    check("stall_state", state_dbg, 0);
    mem_ready = 1'b1;

    // Reset during MEMRD with mem_ready low
    op = 6'b100011;
    tick(); tick(); tick();
    check("ab_memrd", state_dbg, 3);
    mem_ready = 1'b0;
    tick();
    check("ab_hold", state_dbg, 3);
    reset = 1'b0; mem_ready = 1'b1;
    settle();
    check("ab_rst_irwrite", irwrite, 0);
    check("ab_rst_pcen", pcen, 0);
    tick();
    check("ab_rst_state", state_dbg, 0);
    reset = 1'b1; mem_ready = 1'b0;
    regw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (regwrite) regw_cnt++;
      tick();
    end
    check("ab_no_regwrite", regw_cnt, 0);
    check("ab_state", state_dbg, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS core. It sequences the shared datapath (one memory port for instructions and data, one ALU reused for PC increment, branch target and execution) through fetch/decode/execute/memory/writeback states, and drives every datapath enable and mux select. It replaces the single-cycle combinational controller when the core is built as multicycle. It also stalls on a memory-ready handshake so the unified memory may take wait states.

## Interface
Parameters: none. Opcodes, functs and state encodings come from the shared package.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load enable
- pcen  out  1  PC load enable (pcwrite | (branch & zero))
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- regdst  out  1  destination register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write enable
- alucontrol  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported
- state_dbg  out  4  current state encoding, for observation only

## Operation
- Supported instructions: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Moore FSM. All outputs are decoded from the current state, except the following:
  - irwrite and pcen in FETCH are gated by mem_ready.
  - pcen in BEQEX equals zero.
  - alucontrol is combinational from aluop and funct.
- States and their non-zero outputs (every unlisted output is 0):
  - FETCH (0): alusrcb=01, aluop=00. irwrite=pcwrite=mem_ready. Hold in FETCH while mem_ready=0; go to DECODE when it is 1.
  - DECODE (1): alusrcb=11, aluop=00. Next state by op:
    - lw or sw → MEMADR
    - R-type → RTYPEEX
    - beq → BEQEX
    - addi → ADDIEX
    - j → JEX
    - any other op → FETCH, with illegal_op=1
  - MEMADR (2): alusrca=1, alusrcb=10. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD (3): iord=1. Hold while mem_ready=0, then go to MEMWB.
  - MEMWB (4): memtoreg=1, regwrite=1. Next is FETCH.
  - MEMWR (5): iord=1, memwrite=1. memwrite stays high every cycle until mem_ready=1, then go to FETCH.
  - RTYPEEX (6): alusrca=1, alusrcb=00, aluop=10. Next is RTYPEWB.
  - RTYPEWB (7): regdst=1, regwrite=1. Next is FETCH.
  - BEQEX (8): alusrca=1, aluop=01, pcsrc=01, branch=1. Next is FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10. Next is ADDIWB.
  - ADDIWB (10): regwrite=1. Next is FETCH.
  - JEX (11): pcsrc=10, pcwrite=1. Next is FETCH.
  - Encodings 12–15 are unreachable. If reached, go to FETCH with all outputs 0.
- ALU decode:
  - aluop=00 gives add (010); aluop=01 gives sub (110).
  - aluop=10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - An unknown funct gives 010.
- While reset=0, irwrite, pcen, memwrite and regwrite are forced to 0 regardless of state or mem_ready.

## Timing
- Reset: the first rising edge with reset=0 puts the FSM in FETCH. Output values while reset is held low:
  - iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010
  - regdst=0, memtoreg=0, illegal_op=0, state_dbg=0
  - all write enables 0
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.
- reset=0 in the middle of an instruction aborts it at that edge; no partial write is issued afterwards. Release resumes from FETCH.
- mem_ready=1 together with reset=0 is ignored: the state becomes FETCH and irwrite/pcen stay 0.

## Structure
- Package mips_pkg holds:
  - the opcode and funct localparams
  - typedef enum logic[3:0] statetype (FETCH…JEX)
  - typedef logic[1:0] aluop_t
  - the alucontrol constants
- Sub-module aludec (aluop, funct → alucontrol), combinational, instantiated once.
- The state register and next-state/output decode live in the top module.

## Test plan
- Reset held low for 3 cycles with mem_ready=1 → state_dbg=0, irwrite=pcen=regwrite=memwrite=0. First cycle after release: irwrite=pcen=1.
- lw (op 100011), mem_ready always 1 → states 0,1,2,3,4. Exactly one regwrite cycle, with memtoreg=1 and regdst=0. Back in FETCH on cycle 6.
- sw with mem_ready low for 2 cycles in MEMWR → memwrite=1 and iord=1 for 3 consecutive cycles, then FETCH. regwrite is never asserted.
- R-type sub (funct 100010) → alucontrol=110 in RTYPEEX. RTYPEWB has regwrite=1, regdst=1.
- beq run twice, first with zero=1 then with zero=0 → pcen=1 then pcen=0 in BEQEX, pcsrc=01 both times. j → pcen=1, pcsrc=10 in JEX.
- op=111111 → illegal_op pulses for exactly one cycle in DECODE, then FETCH. Separately: reset low during MEMRD with mem_ready=0 → FETCH next cycle, and no regwrite afterwards.
